uart_rx_framer: RTL
===================

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 The block SHALL have parameter BAUD_INC, default 4832, the phase increment per clock; 4832 gives 16x oversampling of 115200 baud from 25 MHz.
REQ-002 The block SHALL have parameter ACC_W, default 16, the phase accumulator width in bits.
REQ-003 The block SHALL have port uart_clk_25m  input  1  clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port uart_rx  input  1  asynchronous serial line, idle high.
REQ-006 The block SHALL have port rx_data  output  8  last correctly framed byte.
REQ-007 The block SHALL have port rx_ready  output  1  one-cycle pulse, rx_data valid; drives the rx FIFO write-request path.
REQ-008 The block SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 The block SHALL have port rx_idle  output  1  line idle for at least 16 consecutive bit times.

Function
REQ-010 uart_rx SHALL pass through a 2-flop synchroniser; the block SHALL use only the synchronised value.
REQ-011 The accumulator SHALL be free running: acc <= (acc + BAUD_INC) mod 2^ACC_W every clock.
REQ-012 tick SHALL be 1 for exactly the clock in which that addition carries out of bit ACC_W-1.
REQ-013 A 4-bit sample counter SHALL advance on tick only, wrapping from 15 to 0, so one bit time is 16 ticks.
REQ-014 The synchronised line SHALL be sampled at counts 7, 8 and 9; the bit value SHALL be the 2-of-3 majority, evaluated at count 9.
REQ-015 The FSM SHALL have exactly five states: IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: on a tick with the line low, the FSM SHALL go to START and clear the sample counter to 0.
REQ-017 START: a majority of 1 at count 9 SHALL return the FSM to IDLE with no output pulse (glitch reject).
REQ-018 START: otherwise, at count 15 the FSM SHALL go to DATA with bit index 0.
REQ-019 DATA: at count 15 the majority bit SHALL be shifted in LSB-first, and the bit index SHALL increment.
REQ-020 DATA: after bit index 7, the FSM SHALL go to STOP.
REQ-021 STOP: a majority of 1 at count 9 SHALL load rx_data from the shift register, pulse rx_ready for one clock, and return to IDLE.
REQ-022 Returning to IDLE at count 9 of the stop bit SHALL leave half a bit of resync margin for back-to-back frames.
REQ-023 STOP: a majority of 0 at count 9 SHALL pulse frame_err for one clock, leave rx_data unchanged, and go to BREAK.
REQ-024 BREAK: the FSM SHALL stay in BREAK until a tick sees the line high, then go to IDLE.
REQ-025 A low line that persists SHALL produce no further frame_err or rx_ready pulses.
REQ-026 rx_ready and frame_err SHALL never be asserted in the same cycle; each frame SHALL produce at most one of them.
REQ-027 rx_data SHALL hold its value until the next rx_ready.
REQ-028 The block SHALL have no backpressure: a full downstream FIFO is the consumer's concern, and the block SHALL never stall.
REQ-029 An idle counter SHALL count ticks while in IDLE with the line high, saturating at 256.
REQ-030 The idle counter SHALL clear on any low sample or on leaving IDLE.
REQ-031 rx_idle SHALL be 1 exactly when the idle counter is at 256.
REQ-032 Latency SHALL be 2 synchroniser clocks plus 9.5 bit times from the start-bit falling edge to rx_ready, within +/-1 tick.

Reset
REQ-033 While reset_n is low, the synchroniser flops SHALL be 1 and acc SHALL be 0.
REQ-034 While reset_n is low, the FSM SHALL be in IDLE, and the counters and shift register SHALL be 0.
REQ-035 While reset_n is low, rx_data SHALL be 0x00, rx_ready and frame_err SHALL be 0, and rx_idle SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame with no pulse.
REQ-037 After reset, the next start edge SHALL be received normally.

Verification
REQ-038 The bench SHALL cover: byte 0x55 at 115200 baud, 8N1 -> a single rx_ready pulse, rx_data=0x55, frame_err=0.
REQ-039 The bench SHALL cover: a 2-tick low glitch on an idle line -> no rx_ready, no frame_err, FSM back in IDLE.
REQ-040 The bench SHALL cover: byte 0x3C followed by a frame with stop bit 0 -> one frame_err pulse, rx_data stays 0x3C.
REQ-041 The bench SHALL cover: line held low 20 bit times, then high, then byte 0xA3 -> exactly one frame_err, then rx_ready with 0xA3.
REQ-042 The bench SHALL cover: 0x00 then 0xFF with no inter-frame gap -> two rx_ready pulses carrying 0x00 and 0xFF, in that order.
REQ-043 The bench SHALL cover: reset_n pulsed low during DATA bit 4 -> all outputs 0; the following byte 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_framer
// Purpose  : 8N1 UART receiver, 16x oversampled from a phase-accumulator tick.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_framer #(
  parameter int BAUD_INC = 4832,
  parameter int ACC_W    = 16
) (
  input  logic       uart_clk_25m,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       rx_idle
);

  localparam logic [ACC_W-1:0] c_BAUD_INC  = BAUD_INC[ACC_W-1:0];
  localparam logic [8:0]       c_IDLE_FULL = 9'd256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic [ACC_W-1:0] r_acc;
  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shreg;
  logic [1:0]       r_samp;
  logic             r_bit;
  logic [8:0]       r_idle_cnt;

  logic [ACC_W:0]   w_sum;
  logic             w_tick;
  logic             w_line;
  logic             w_maj;

  assign w_sum  = {1'b0, r_acc} + {1'b0, c_BAUD_INC};
  assign w_tick = w_sum[ACC_W];
  assign w_line = r_sync2;
  // 2-of-3 vote over the samples taken at counts 7, 8 and the live one at 9
  assign w_maj  = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_line) | (r_samp[1] & w_line);

  assign rx_idle = (r_idle_cnt == c_IDLE_FULL);

  always_ff @(posedge uart_clk_25m or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_acc   <= '0;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_acc   <= w_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge uart_clk_25m or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shreg    <= '0;
      r_samp     <= '0;
      r_bit      <= 1'b0;
      r_idle_cnt <= '0;
      rx_data    <= '0;
      rx_ready   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      if (w_tick) begin
        if (r_state != IDLE) begin
          r_idle_cnt <= '0;
          if (r_cnt == 4'd7) r_samp[0] <= w_line;
          if (r_cnt == 4'd8) r_samp[1] <= w_line;
          if (r_cnt == 4'd9) r_bit     <= w_maj;
        end
        case (r_state)
          IDLE: begin
            r_cnt <= '0;
            r_idx <= '0;
            if (!w_line) begin
              r_state    <= START;
              r_idle_cnt <= '0;
            end else if (r_idle_cnt != c_IDLE_FULL) begin
              r_idle_cnt <= r_idle_cnt + 9'd1;
            end
          end
          START: begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd9 && w_maj) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == 4'd15) begin
              r_state <= DATA;
              r_idx   <= '0;
            end
          end
          DATA: begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_shreg <= {r_bit, r_shreg[7:1]};
              r_idx   <= r_idx + 3'd1;
              if (r_idx == 3'd7) r_state <= STOP;
            end
          end
          STOP: begin
            r_cnt <= r_cnt + 4'd1;
            // Leaving at mid-stop gives half a bit to catch a back-to-back start edge
            if (r_cnt == 4'd9) begin
              r_cnt <= '0;
              if (w_maj) begin
                rx_data  <= r_shreg;
                rx_ready <= 1'b1;
                r_state  <= IDLE;
              end else begin
                frame_err <= 1'b1;
                r_state   <= BREAK;
              end
            end
          end
          BREAK: begin
            r_cnt <= '0;
            if (w_line) r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
